// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Multi-cycle sequencer for the logic-ALU + single-read-port register
//            file datapath. Optional macro SAME_SRC_SKIP_EN skips the second
//            register read when both source registers are the same.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_imm,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [ADDR_W-1:0] in_src_a,
  input  logic [ADDR_W-1:0] in_src_b,
  input  logic [DATA_W-1:0] in_imm_a,
  input  logic [DATA_W-1:0] in_imm_b,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic              rf_write_en,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD_A = 2'd1,
    S_RD_B = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [OP_W-1:0]    r_op;
  logic [ADDR_W-1:0]  r_dst;
  logic [ADDR_W-1:0]  r_src_a;
  logic [ADDR_W-1:0]  r_src_b;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic               w_accept;
  logic               w_skip;

  assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef SAME_SRC_SKIP_EN
  // One read serves both operands when the sources match.
  assign w_skip = (r_src_a == r_src_b);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = in_imm ? S_WB : S_RD_A;
        end
      end
      S_RD_A:  w_next = w_skip ? S_WB : S_RD_B;
      S_RD_B:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_dst     <= '0;
      r_src_a   <= '0;
      r_src_b   <= '0;
      r_rd_addr <= '0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= in_opcode;
            r_dst   <= in_dst;
            r_src_a <= in_src_a;
            r_src_b <= in_src_b;
            if (in_imm) begin
              r_a <= in_imm_a;
              r_b <= in_imm_b;
            end
          end
        end
        S_RD_A: begin
          r_a       <= rf_read_data;
          r_rd_addr <= r_src_a;
          if (w_skip) begin
            r_b <= rf_read_data;
          end
        end
        S_RD_B: begin
          r_b       <= rf_read_data;
          r_rd_addr <= r_src_b;
        end
        default: begin
        end
      endcase
    end
  end

  // Read address follows the active read state, otherwise holds the last one used.
  always_comb begin
    rf_read_addr = r_rd_addr;
    if (r_state == S_RD_A) begin
      rf_read_addr = r_src_a;
    end else if (r_state == S_RD_B) begin
      rf_read_addr = r_src_b;
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rf_write_en   = (r_state == S_WB);
  assign done          = (r_state == S_WB);
  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_opcode    = r_op;
  assign rf_write_addr = r_dst;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed self-checking bench with a register file + logic ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_imm = 1'b0;
  logic [1:0] in_opcode = '0;
  logic [2:0] in_dst = '0;
  logic [2:0] in_src_a = '0;
  logic [2:0] in_src_b = '0;
  logic [7:0] in_imm_a = '0;
  logic [7:0] in_imm_b = '0;
  logic [2:0] rf_read_addr;
  logic [7:0] rf_read_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_opcode;
  logic [2:0] rf_write_addr;
  logic       rf_write_en;
  logic       done;
  logic       busy;

  logic [7:0] rf [8] = '{default: 8'h00};
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int acc_cyc = 0;
  int last_wait = 0;
  int n_chk = 0;
  int n_err = 0;
  int w0 = 0;
  int exp_lat = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_opcode(in_opcode), .in_dst(in_dst),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_imm_a(in_imm_a),
    .in_imm_b(in_imm_b), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .rf_write_addr(rf_write_addr),
    .rf_write_en(rf_write_en), .done(done), .busy(busy)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  assign rf_read_data = rf[rf_read_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_write_en) begin
      rf[rf_write_addr] <= alu_f(alu_a, alu_b, alu_opcode);
      wr_cnt            <= wr_cnt + 1;
      last_wr_cyc       <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic imm, input logic [1:0] op, input logic [2:0] dst,
                      input logic [2:0] sa, input logic [2:0] sb,
                      input logic [7:0] ia, input logic [7:0] ib, input bit keep);
    int t;
    in_imm = imm; in_opcode = op; in_dst = dst; in_src_a = sa; in_src_b = sb;
    in_imm_a = ia; in_imm_b = ib; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    last_wait = t;
    if (t >= 20) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc - 1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_write(input int n0);
    int t;
    t = 0;
    while (wr_cnt == n0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) chk("write_timeout", wr_cnt, n0 + 1);
  endtask

  initial begin
`ifdef SAME_SRC_SKIP_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_en", {31'd0, rf_write_en}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_rd_addr", {29'd0, rf_read_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while in RD_A: write to r5 must be dropped
    send(1'b0, 2'b01, 3'd5, 3'd0, 3'd1, 8'h00, 8'h00, 1'b0);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_wr_en", {31'd0, rf_write_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_no_write", wr_cnt, 32'd0);

    // Immediate OR F0|0F -> r1
    send(1'b1, 2'b01, 3'd1, 3'd0, 3'd0, 8'hF0, 8'h0F, 1'b0);
    chk("imm_wr_en", {31'd0, rf_write_en}, 32'd1);
    chk("imm_done", {31'd0, done}, 32'd1);
    chk("imm_wr_addr", {29'd0, rf_write_addr}, 32'd1);
    chk("imm_busy", {31'd0, busy}, 32'd1);
    wait_write(0);
    chk("imm_latency", last_wr_cyc - acc_cyc, 32'd1);
    chk("r1_ff", {24'd0, rf[1]}, 32'hFF);
    chk("imm_wr_en_off", {31'd0, rf_write_en}, 32'd0);

    // Immediate AND AA&FF -> r2, then NAND r1,r2 -> r3
    send(1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 8'hAA, 8'hFF, 1'b0);
    wait_write(1);
    chk("r2_aa", {24'd0, rf[2]}, 32'hAA);
    send(1'b0, 2'b10, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0);
    chk("rda_addr", {29'd0, rf_read_addr}, 32'd1);
    chk("rda_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rdb_addr", {29'd0, rf_read_addr}, 32'd2);
    @(negedge clk);
    chk("wb_addr_hold", {29'd0, rf_read_addr}, 32'd2);
    chk("wb_alu_a", {24'd0, alu_a}, 32'hFF);
    chk("wb_alu_b", {24'd0, alu_b}, 32'hAA);
    wait_write(2);
    chk("nand_latency", last_wr_cyc - acc_cyc, 32'd3);
    chk("r3_55", {24'd0, rf[3]}, 32'h55);

    // NOR r3,r3 -> r3 (same-source case)
    send(1'b0, 2'b11, 3'd3, 3'd3, 3'd3, 8'h00, 8'h00, 1'b0);
    wait_write(3);
    chk("nor_latency", last_wr_cyc - acc_cyc, exp_lat);
    chk("r3_aa", {24'd0, rf[3]}, 32'hAA);

    // Four dependent register ops with in_valid held high
    w0 = wr_cnt;
    send(1'b0, 2'b00, 3'd5, 3'd1, 3'd3, 8'h00, 8'h00, 1'b1);
    w0 = acc_cyc;
    send(1'b0, 2'b01, 3'd6, 3'd5, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("hold_gap1", acc_cyc - w0, 32'd4);
    chk("hold_wait1", last_wait, 32'd3);
    w0 = acc_cyc;
    send(1'b0, 2'b10, 3'd7, 3'd6, 3'd1, 8'h00, 8'h00, 1'b1);
    chk("hold_gap2", acc_cyc - w0, 32'd4);
    w0 = acc_cyc;
    send(1'b0, 2'b11, 3'd0, 3'd7, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("hold_gap3", acc_cyc - w0, 32'd4);
    chk("hold_wait3", last_wait, 32'd3);
    wait_write(6);
    repeat (3) @(negedge clk);
    chk("hold_wr_cnt", wr_cnt, 32'd8);
    chk("r5_aa", {24'd0, rf[5]}, 32'hAA);
    chk("r6_aa", {24'd0, rf[6]}, 32'hAA);
    chk("r7_55", {24'd0, rf[7]}, 32'h55);
    chk("r0_aa", {24'd0, rf[0]}, 32'hAA);

    // Preload r4=0x11, then reset during RD_B of OR r0,r2 -> r4
    send(1'b1, 2'b01, 3'd4, 3'd0, 3'd0, 8'h11, 8'h00, 1'b0);
    wait_write(8);
    chk("r4_pre", {24'd0, rf[4]}, 32'h11);
    send(1'b0, 2'b01, 3'd4, 3'd0, 3'd2, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("rdb_read_addr", {29'd0, rf_read_addr}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rdb_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rdb_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("r4_kept", {24'd0, rf[4]}, 32'h11);
    chk("rdb_no_write", wr_cnt, 32'd9);
    chk("rdb_idle", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
